// File: rtl/score_seg7_display.sv
// Binary-to-BCD converter and 4-digit multiplexed 7-segment driver.
// Ports: clock, reset_n, count[9:0] in; bcd, conv_done, busy, an, seg, dp out.
module score_seg7_display #(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [9:0]  count,
  output logic [15:0] bcd,
  output logic        conv_done,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [9:0]  last_count, last_nxt;
  logic [25:0] sh, sh_nxt, sh_adj, sh_step;
  logic [3:0]  iter, iter_nxt;
  logic [15:0] bcd_nxt;
  logic        done_nxt;

  // One double-dabble iteration: correct nibbles >= 5, then shift.
  always_comb begin
    sh_adj = sh;
    for (int i = 0; i < 4; i++) begin
      if (sh[10+4*i +: 4] >= 4'd5)
        sh_adj[10+4*i +: 4] = sh[10+4*i +: 4] + 4'd3;
    end
    sh_step = {sh_adj[24:0], 1'b0};
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_count;
    sh_nxt    = sh;
    iter_nxt  = iter;
    bcd_nxt   = bcd;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (count != last_count) begin
          sh_nxt    = {16'b0, count};
          last_nxt  = count;
          iter_nxt  = 4'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        sh_nxt = sh_step;
        if (iter == 4'd9)
          state_nxt = DONE;
        else
          iter_nxt = iter + 4'd1;
      end
      DONE: begin
        bcd_nxt   = sh[25:10];
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_count <= '0;
      sh         <= '0;
      iter       <= '0;
      bcd        <= '0;
      conv_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_count <= last_nxt;
      sh         <= sh_nxt;
      iter       <= iter_nxt;
      bcd        <= bcd_nxt;
      conv_done  <= done_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign dp   = 1'b1;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg_nxt;
  logic [3:0]        an_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Leading-zero blanking: a digit is dark when it and all above are 0.
  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (digit)
      2'd0: nib = bcd[3:0];
      2'd1: begin
        nib   = bcd[7:4];
        blank = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = bcd[11:8];
        blank = (bcd[15:8] == 8'd0);
      end
      2'd3: begin
        nib   = bcd[15:12];
        blank = (bcd[15:12] == 4'd0);
      end
      default: nib = bcd[3:0];
    endcase
  end

  always_comb begin
    seg_nxt = 7'h7F;
    if (!blank) begin
      case (nib)
        4'd0:    seg_nxt = 7'b1000000;
        4'd1:    seg_nxt = 7'b1111001;
        4'd2:    seg_nxt = 7'b0100100;
        4'd3:    seg_nxt = 7'b0110000;
        4'd4:    seg_nxt = 7'b0011001;
        4'd5:    seg_nxt = 7'b0010010;
        4'd6:    seg_nxt = 7'b0000010;
        4'd7:    seg_nxt = 7'b1111000;
        4'd8:    seg_nxt = 7'b0000000;
        4'd9:    seg_nxt = 7'b0010000;
        default: seg_nxt = 7'h7F;
      endcase
    end
    an_nxt = ~(4'b0001 << digit);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule
